// File: rtl/pipeline_run_ctrl.sv
// Execution sequencer for the five-stage pipeline: global enable, stall controls,
// RUN/STEP/HALT command handling and drain-to-finish after a decoded halt instruction.
module pipeline_run_ctrl #(
  parameter int NB_CYCLES    = 32,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  input  logic [1:0]           i_cmd,
  output logic                 o_cmd_ready,
  input  logic                 i_hazard,
  input  logic                 i_halt_instr,
  output logic                 o_valid,
  output logic                 o_fetch_en,
  output logic                 o_bubble,
  output logic [2:0]           o_state,
  output logic                 o_finished,
  output logic [NB_CYCLES-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_RUN      = 3'b001,
    S_STEP     = 3'b010,
    S_DRAIN    = 3'b011,
    S_FINISHED = 3'b100
  } state_e;

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;

  // Drain counter only needs to hold DRAIN_CYCLES-1.
  localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic [NB_CYCLES-1:0]   count_q, count_d;
  logic                   cmd_fire;
  logic                   halt_taken;

  // State register
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
      drain_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      count_q <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    count_d = count_q;
    if (o_valid && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        if (cmd_fire && (i_cmd == CMD_RUN)) begin
          state_d = S_RUN;
        end else if (cmd_fire && (i_cmd == CMD_STEP)) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        // A taken halt beats a simultaneous pause; the command is still consumed.
        if (halt_taken) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else if (cmd_fire && (i_cmd == CMD_HALT)) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (halt_taken) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_q == '0) begin
          state_d = S_FINISHED;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      S_FINISHED: state_d = S_FINISHED;
      default:    state_d = S_IDLE;
    endcase
  end

  // Output decode; stall controls are combinational on the hazard request
  always_comb begin
    o_valid       = (state_q == S_RUN) || (state_q == S_STEP) || (state_q == S_DRAIN);
    o_cmd_ready   = (state_q == S_IDLE) || (state_q == S_RUN);
    o_finished    = (state_q == S_FINISHED);
    o_state       = state_q;
    o_fetch_en    = o_valid && !i_hazard && (state_q != S_DRAIN);
    o_bubble      = o_valid && i_hazard;
    o_cycle_count = count_q;
    cmd_fire      = i_cmd_valid && o_cmd_ready;
    halt_taken    = o_valid && i_halt_instr && !i_hazard;
  end

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Scoreboard bench for pipeline_run_ctrl: stimulus queues expected outputs per cycle,
// a monitor pops and compares them at the falling edge.
module tb_pipeline_run_ctrl;

  localparam logic [2:0] S_I = 3'b000, S_R = 3'b001, S_S = 3'b010, S_D = 3'b011, S_F = 3'b100;
  localparam logic [1:0] C_NOP = 2'b00, C_RUN = 2'b01, C_STEP = 2'b10, C_HALT = 2'b11;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic [1:0]  i_cmd = 2'b00;
  logic        i_hazard = 1'b0;
  logic        i_halt_instr = 1'b0;

  logic        cmd_ready, valid, fetch_en, bubble, finished;
  logic [2:0]  state;
  logic [31:0] cycle_count;
  logic        cmd_ready4, valid4, fetch_en4, bubble4, finished4;
  logic [2:0]  state4;
  logic [3:0]  cycle_count4;

  always #5 clk = ~clk;

  pipeline_run_ctrl #(.NB_CYCLES(32), .DRAIN_CYCLES(3)) dut (
    .i_clock(clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(cmd_ready), .i_hazard(i_hazard), .i_halt_instr(i_halt_instr),
    .o_valid(valid), .o_fetch_en(fetch_en), .o_bubble(bubble), .o_state(state),
    .o_finished(finished), .o_cycle_count(cycle_count)
  );

  // Narrow-counter instance sharing the same stimulus, used for saturation
  pipeline_run_ctrl #(.NB_CYCLES(4), .DRAIN_CYCLES(3)) dut4 (
    .i_clock(clk), .i_reset(i_reset), .i_cmd_valid(i_cmd_valid), .i_cmd(i_cmd),
    .o_cmd_ready(cmd_ready4), .i_hazard(i_hazard), .i_halt_instr(i_halt_instr),
    .o_valid(valid4), .o_fetch_en(fetch_en4), .o_bubble(bubble4), .o_state(state4),
    .o_finished(finished4), .o_cycle_count(cycle_count4)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  st;
    logic        v, f, b, r, fin;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t        exp_q[$];
  string       name_q[$];
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_cnt = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic [1:0] c, input logic hz, input logic hl);
    i_cmd_valid  = cv;
    i_cmd        = c;
    i_hazard     = hz;
    i_halt_instr = hl;
  endtask

  // Expected count is the number of enabled cycles seen so far
  task automatic expect_out(input string name, input logic [2:0] st, input logic v,
                            input logic f, input logic b, input logic r, input logic fin);
    exp_t e;
    e.cyc  = cyc;
    e.st   = st;
    e.v    = v;
    e.f    = f;
    e.b    = b;
    e.r    = r;
    e.fin  = fin;
    e.cnt  = exp_cnt;
    e.cnt4 = (exp_cnt > 32'd15) ? 4'd15 : exp_cnt[3:0];
    exp_q.push_back(e);
    name_q.push_back(name);
    if (v) exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic cyc_step(input string name, input logic cv, input logic [1:0] c,
                          input logic hz, input logic hl, input logic [2:0] st,
                          input logic v, input logic f, input logic b, input logic r,
                          input logic fin);
    next_cycle();
    drive(cv, c, hz, hl);
    expect_out(name, st, v, f, b, r, fin);
  endtask

  initial begin : monitor
    exp_t  e;
    string n;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        tests++;
        if (int'(e.cyc) != cyc) begin
          fails++;
          $display("FAIL %s: stale expectation for cycle %0d checked at cycle %0d", n, e.cyc, cyc);
        end else if ({state, valid, fetch_en, bubble, cmd_ready, finished, cycle_count, cycle_count4}
                     !== {e.st, e.v, e.f, e.b, e.r, e.fin, e.cnt, e.cnt4}) begin
          fails++;
          $display("FAIL %s @%0d: got st=%b v=%b f=%b b=%b rdy=%b fin=%b cnt=%0d cnt4=%0d, want st=%b v=%b f=%b b=%b rdy=%b fin=%b cnt=%0d cnt4=%0d",
                   n, cyc, state, valid, fetch_en, bubble, cmd_ready, finished, cycle_count, cycle_count4,
                   e.st, e.v, e.f, e.b, e.r, e.fin, e.cnt, e.cnt4);
        end else begin
          $display("[TB] ok %s @%0d st=%b v=%b cnt=%0d", n, cyc, state, valid, cycle_count);
        end
      end
    end
  end

  initial begin : stimulus
    // Reset held for two edges, then released
    drive(1'b0, C_NOP, 1'b0, 1'b0);
    next_cycle();
    next_cycle();
    i_reset = 1'b1;
    expect_out("reset", S_I, 0, 0, 0, 1, 0);
    for (int k = 0; k < 10; k++) cyc_step("idle", 0, C_NOP, 0, 0, S_I, 0, 0, 0, 1, 0);

    // Three single steps
    for (int k = 0; k < 3; k++) begin
      cyc_step("step_issue", 1, C_STEP, 0, 0, S_I, 0, 0, 0, 1, 0);
      cyc_step("step_pulse", 0, C_NOP,  0, 0, S_S, 1, 1, 0, 0, 0);
      cyc_step("step_gap",   0, C_NOP,  0, 0, S_I, 0, 0, 0, 1, 0);
    end

    // Run, pause, resume
    cyc_step("run_cmd", 1, C_RUN, 0, 0, S_I, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) cyc_step("run", 0, C_NOP, 0, 0, S_R, 1, 1, 0, 1, 0);
    cyc_step("pause_cmd", 1, C_HALT, 0, 0, S_R, 1, 1, 0, 1, 0);
    for (int k = 0; k < 4; k++) cyc_step("pause", 0, C_NOP, 0, 0, S_I, 0, 0, 0, 1, 0);
    cyc_step("resume_cmd", 1, C_RUN, 0, 0, S_I, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) cyc_step("resume", 0, C_NOP, 0, 0, S_R, 1, 1, 0, 1, 0);

    // Hazard while running, then while idle
    cyc_step("hazard1", 0, C_NOP, 1, 0, S_R, 1, 0, 1, 1, 0);
    cyc_step("hazard2", 0, C_NOP, 1, 0, S_R, 1, 0, 1, 1, 0);
    cyc_step("hazard_end", 0, C_NOP, 0, 0, S_R, 1, 1, 0, 1, 0);
    cyc_step("pause2_cmd", 1, C_HALT, 0, 0, S_R, 1, 1, 0, 1, 0);
    cyc_step("idle_hazard", 0, C_NOP, 1, 0, S_I, 0, 0, 0, 1, 0);
    cyc_step("idle_hazard_halt", 0, C_NOP, 1, 1, S_I, 0, 0, 0, 1, 0);

    // Halt instruction: stalled once, then taken; drain then finish
    cyc_step("run_cmd2", 1, C_RUN, 0, 0, S_I, 0, 0, 0, 1, 0);
    cyc_step("run2", 0, C_NOP, 0, 0, S_R, 1, 1, 0, 1, 0);
    cyc_step("run2", 0, C_NOP, 0, 0, S_R, 1, 1, 0, 1, 0);
    cyc_step("halt_stalled", 0, C_NOP, 1, 1, S_R, 1, 0, 1, 1, 0);
    cyc_step("halt_taken",   0, C_NOP, 0, 1, S_R, 1, 1, 0, 1, 0);
    for (int k = 0; k < 3; k++) cyc_step("drain", 1, C_RUN, 0, 0, S_D, 1, 0, 0, 0, 0);
    cyc_step("finished", 1, C_RUN,  0, 0, S_F, 0, 0, 0, 0, 1);
    cyc_step("finished", 1, C_STEP, 1, 0, S_F, 0, 0, 0, 0, 1);
    cyc_step("finished", 1, C_HALT, 0, 1, S_F, 0, 0, 0, 0, 1);
    cyc_step("finished", 0, C_NOP,  0, 0, S_F, 0, 0, 0, 0, 1);
    next_cycle();
    i_reset = 1'b0;
    drive(0, C_NOP, 0, 0);
    expect_out("finished_rst", S_F, 0, 0, 0, 0, 1);
    exp_cnt = 32'd0;
    next_cycle();
    i_reset = 1'b1;
    expect_out("rst_from_finished", S_I, 0, 0, 0, 1, 0);

    // Halt command coincident with taken halt; reset in second drain cycle
    cyc_step("run_cmd3", 1, C_RUN, 0, 0, S_I, 0, 0, 0, 1, 0);
    cyc_step("run3", 0, C_NOP, 0, 0, S_R, 1, 1, 0, 1, 0);
    cyc_step("halt_and_cmd", 1, C_HALT, 0, 1, S_R, 1, 1, 0, 1, 0);
    cyc_step("drain_a", 0, C_NOP, 0, 0, S_D, 1, 0, 0, 0, 0);
    next_cycle();
    i_reset = 1'b0;
    drive(0, C_NOP, 0, 0);
    expect_out("drain_b_rst", S_D, 1, 0, 0, 0, 0);
    exp_cnt = 32'd0;
    next_cycle();
    i_reset = 1'b1;
    expect_out("rst_mid_drain", S_I, 0, 0, 0, 1, 0);

    // Long run: narrow counter saturates at 15
    cyc_step("run_cmd4", 1, C_RUN, 0, 0, S_I, 0, 0, 0, 1, 0);
    for (int k = 0; k < 20; k++) cyc_step("sat_run", 0, C_NOP, 0, 0, S_R, 1, 1, 0, 1, 0);
    cyc_step("sat_pause_cmd", 1, C_HALT, 0, 0, S_R, 1, 1, 0, 1, 0);
    cyc_step("sat_idle", 0, C_NOP, 0, 0, S_I, 0, 0, 0, 1, 0);
    cyc_step("sat_idle", 0, C_NOP, 0, 0, S_I, 0, 0, 0, 1, 0);

    // Every queued expectation must have been consumed by the monitor
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_queue: %0d expectations left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
